// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit sitting beside the ALU in EX.
// Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns the HI/LO registers and
// raises busy while a multiply or divide is in flight so the hazard unit
// can stall later HI/LO consumers.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   EX holds an md op this cycle (one-cycle pulse)
//   md_op  in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   op_a   in  32   rs operand
//   op_b   in  32   rt operand
//   flush  in   1   abandon in-flight op, no HI/LO update
//   busy   out  1   unit computing
//   hi     out 32   HI register
//   lo     out 32   LO register
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        ext_a, ext_b, prod;
    logic               a_neg, b_neg;
    logic [31:0]        mag_a, mag_b, uq, ur, quot, rem;

    // Result datapath works only on the latched operands, so the outputs
    // never see op_a/op_b combinationally and late operand changes are harmless.
    // Sign-extending both operands to 64 bits makes the low 64 bits of a
    // plain multiply equal to the signed product.
    always_comb begin
        ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = ext_a * ext_b;
    end

    // Signed division is done on magnitudes and the signs restored afterwards:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 naturally wraps back to 0x80000000 with remainder 0.
    always_comb begin
        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        mag_a = a_neg ? (32'd0 - a_q) : a_q;
        mag_b = b_neg ? (32'd0 - b_q) : b_q;
        uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
        ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
        quot  = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem   = a_neg ? (32'd0 - ur) : ur;
    end

    // Next-state logic. Flush wins over everything, including a completing
    // op and a start in the same cycle. Starts are only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                a_d     = op_a;
                                b_d     = op_b;
                                sgn_d   = ~md_op[0];
                                state_d = MUL;
                                busy_d  = 1'b1;
                                cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            end
                            3'd2, 3'd3: begin
                                a_d     = op_a;
                                b_d     = op_b;
                                sgn_d   = ~md_op[0];
                                state_d = DIV;
                                busy_d  = 1'b1;
                                cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            end
                            3'd4:    hi_d = op_a;
                            3'd5:    lo_d = op_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV: begin
                    if (cnt_q == '0) begin
                        // Divide by zero still takes the full latency but leaves HI/LO alone.
                        if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. The driver issues operations,
// updates an arithmetic model of HI/LO and queues the expected HI/LO plus the
// cycle it should appear and how long busy should have been high. A separate
// monitor samples the DUT after every rising edge and retires entries.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        string       name;
        int          due;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definition.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sbv; model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd1: begin p = ua * ub;  model_hi = p[63:32]; model_lo = p[31:0]; end
            3'd2: if (b != 32'd0) begin
                q = sa / sbv;
                r = sa % sbv;
                p = q; model_lo = p[31:0];
                p = r; model_hi = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                model_lo = a / b;
                model_hi = a % b;
            end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
    endtask

    // Monitor: samples 1 time unit after each rising edge, tracks busy run
    // lengths and retires the scoreboard entry that is due this cycle.
    logic prev_busy = 1'b0;
    int   run = 0;
    int   last_run = 0;
    initial begin
        forever begin
            logic fell;
            exp_t e;
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            fell = prev_busy && !busy;
            if (busy) run++;
            else if (prev_busy) begin
                last_run = run;
                run = 0;
            end
            if (busy && (sb.size() == 0 || sb[0].len == 0)) begin
                errors++;
                $display("[TB] FAIL busy_spurious: got busy=1 expected busy=0 (cycle %0d)", cyc);
            end
            if (fell && sb.size() > 0 && sb[0].len > 0 && sb[0].due != cyc) begin
                errors++;
                $display("[TB] FAIL %s_early_fall: got busy fall at cycle %0d expected at %0d",
                         sb[0].name, cyc, sb[0].due);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput({e.name, "_hi"}, hi, e.hi);
                checkOutput({e.name, "_lo"}, lo, e.lo);
                checkOutput({e.name, "_busy_low"}, {31'd0, busy}, 32'd0);
                if (e.len > 0) begin
                    checkOutput({e.name, "_busy_fell"}, {31'd0, fell}, 32'd1);
                    checkOutput({e.name, "_busy_len"}, last_run, e.len);
                end
            end
            prev_busy = busy;
        end
    end

    // Issue one operation. flush_at: for MUL/DIV the busy cycle (1..latency)
    // whose edge sees flush; for other ops any nonzero value flushes in the
    // issue cycle. inj: busy cycle in which a stray start is driven (0 = none).
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int flush_at, input int inj);
        int   p, len, stop;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        op_a  = a;
        op_b  = b;
        flush = 1'b0;
        p     = cyc + 1;
        len   = (op <= 3'd1) ? MULT_N : ((op <= 3'd3) ? DIV_N : 0);
        e.name = name;
        if (len > 0) begin
            if (flush_at > 0) begin
                stop  = flush_at;
                e.len = flush_at;
            end else begin
                modelOp(op, a, b);
                stop  = len;
                e.len = len;
            end
        end else begin
            stop  = 0;
            e.len = 0;
            if (flush_at > 0) flush = 1'b1;
            else modelOp(op, a, b);
        end
        e.due = p + e.len;
        e.hi  = model_hi;
        e.lo  = model_lo;
        sb.push_back(e);
        for (int k = 1; k <= stop; k++) begin
            @(negedge clk);
            op_a  = $urandom;
            op_b  = $urandom;
            md_op = 3'($urandom_range(0, 7));
            start = (k == inj);
            flush = (k == flush_at);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        for (int t = 0; t < 40 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        md_op = 3'd0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        #12;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        checkOutput("mult_neg2x3_hi_const", hi, 32'hFFFF_FFFF);
        checkOutput("mult_neg2x3_lo_const", lo, 32'hFFFF_FFFA);
        applyStimulus("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2);
        checkOutput("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo_const", lo, 32'h0000_0001);
        applyStimulus("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3);
        checkOutput("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        checkOutput("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
        applyStimulus("divu_7_2", 3'd3, 32'd7, 32'd2, 0, 0);
        checkOutput("divu_7_2_lo_const", lo, 32'd3);
        checkOutput("divu_7_2_hi_const", hi, 32'd1);
        applyStimulus("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("mthi", 3'd4, 32'h1234_5678, 32'd0, 0, 0);
        applyStimulus("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0, 0, 0);
        applyStimulus("div_by0", 3'd2, 32'd99, 32'd0, 0, 5);
        checkOutput("div_by0_hi_const", hi, 32'h1234_5678);
        checkOutput("div_by0_lo_const", lo, 32'h9ABC_DEF0);
        applyStimulus("div_flush4", 3'd2, 32'd100, 32'd7, 4, 2);
        applyStimulus("div_flush_last", 3'd3, 32'd100, 32'd7, DIV_N, 0);
        applyStimulus("mul_flush_last", 3'd0, 32'd9, 32'd9, MULT_N, 0);
        applyStimulus("mthi_flushed", 3'd4, 32'hDEAD_BEEF, 32'd0, 1, 0);
        applyStimulus("noop6", 3'd6, 32'hAAAA_AAAA, 32'd1, 0, 0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd0;
        op_a  = 32'd1234;
        op_b  = 32'd5678;
        sb.push_back('{name: "mult_reset", due: cyc + 1 + MULT_N, len: MULT_N,
                       hi: model_hi, lo: model_lo});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_hi", hi, 32'd0);
        checkOutput("async_reset_lo", lo, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("mult_6x7", 3'd0, 32'd6, 32'd7, 0, 0);
        checkOutput("mult_6x7_lo_const", lo, 32'd42);
        checkOutput("mult_6x7_hi_const", hi, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            int         fa, inj, len;
            op  = 3'($urandom_range(0, 7));
            len = (op <= 3'd1) ? MULT_N : ((op <= 3'd3) ? DIV_N : 1);
            fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
            inj = ($urandom_range(0, 1) == 0) ? $urandom_range(1, len) : 0;
            applyStimulus($sformatf("rand%0d_op%0d", i, op), op, pickOperand(), pickOperand(), fa, inj);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
